// File: rtl/window_scan_sequencer.sv
// Address sequencer for a 12x12 feature map. It walks four quadrants, each split into
// non-overlapping WIN x WIN windows, and drives the strobes of an external column counter.
module window_scan_sequencer #(
  parameter int WIN   = 3,
  parameter int QUAD  = 6,
  parameter int IDX_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             pixel_ready,
  input  logic             new_quadrant_row,
  output logic             en,
  output logic             clear,
  output logic             new_row,
  output logic             new_vector,
  output logic [1:0]       quadrant,
  output logic             quadrant_lsb,
  output logic [IDX_W-1:0] row_index,
  output logic             pixel_valid,
  output logic             busy,
  output logic             done,
  output logic             sync_err
);

  localparam int NWIN = QUAD / WIN;
  localparam int PW   = (WIN  > 1) ? $clog2(WIN)  : 1;
  localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;

  localparam logic [PW-1:0] LAST_PIX = PW'(WIN - 1);
  localparam logic [WW-1:0] LAST_WIN = WW'(NWIN - 1);

  typedef enum logic [1:0] {IDLE, CLR, SCAN, FIN} state_t;

  state_t        state, state_nxt;
  logic [1:0]    quad_q, quad_nxt;
  logic [WW-1:0] wr_q, wr_nxt, wc_q, wc_nxt;
  logic [PW-1:0] r_q, r_nxt, c_q, c_nxt;
  logic          sync_q, sync_nxt;

  logic [IDX_W-1:0] base_row;
  logic [IDX_W-1:0] win_row;

  assign base_row = quad_q[1] ? IDX_W'(QUAD) : '0;
  assign win_row  = IDX_W'(WIN) * IDX_W'(wr_q);

  assign quadrant     = quad_q;
  assign quadrant_lsb = quad_q[0];
  assign sync_err     = sync_q;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    quad_nxt    = quad_q;
    wr_nxt      = wr_q;
    wc_nxt      = wc_q;
    r_nxt       = r_q;
    c_nxt       = c_q;
    sync_nxt    = sync_q;
    en          = 1'b0;
    clear       = 1'b0;
    new_row     = 1'b0;
    new_vector  = 1'b0;
    pixel_valid = 1'b0;
    done        = 1'b0;
    busy        = (state != IDLE);
    row_index   = '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLR;
          quad_nxt  = 2'd0;
          sync_nxt  = 1'b0;
        end
      end

      CLR: begin
        clear     = 1'b1;
        row_index = base_row;
        wr_nxt    = '0;
        wc_nxt    = '0;
        r_nxt     = '0;
        c_nxt     = '0;
        state_nxt = SCAN;
      end

      SCAN: begin
        pixel_valid = 1'b1;
        row_index   = base_row + win_row + IDX_W'(r_q);
        if (pixel_ready) begin
          en = 1'b1;
          if (c_q != LAST_PIX) begin
            c_nxt = c_q + 1'b1;
          end else if (r_q != LAST_PIX) begin
            new_row = 1'b1;
            c_nxt   = '0;
            r_nxt   = r_q + 1'b1;
          end else begin
            new_vector = 1'b1;
            c_nxt      = '0;
            r_nxt      = '0;
            // The counter flags the last window column of a quadrant row; it must agree.
            if (new_quadrant_row != (wc_q == LAST_WIN)) sync_nxt = 1'b1;
            if (wc_q != LAST_WIN) begin
              wc_nxt = wc_q + 1'b1;
            end else begin
              wc_nxt = '0;
              if (wr_q != LAST_WIN) begin
                wr_nxt = wr_q + 1'b1;
              end else begin
                wr_nxt = '0;
                if (quad_q == 2'd3) begin
                  state_nxt = FIN;
                end else begin
                  quad_nxt  = quad_q + 2'd1;
                  state_nxt = CLR;
                end
              end
            end
          end
        end
      end

      FIN: begin
        done      = 1'b1;
        quad_nxt  = 2'd0;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      quad_q <= 2'd0;
      wr_q   <= '0;
      wc_q   <= '0;
      r_q    <= '0;
      c_q    <= '0;
      sync_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      quad_q <= quad_nxt;
      wr_q   <= wr_nxt;
      wc_q   <= wc_nxt;
      r_q    <= r_nxt;
      c_q    <= c_nxt;
      sync_q <= sync_nxt;
    end
  end

endmodule

// File: tb/tb_window_scan_sequencer.sv
// Bench for window_scan_sequencer with a behavioural column counter attached; checks
// a cycle table, directed corner cases and randomized full scans against a pixel-list model.
module tb_window_scan_sequencer;

  localparam int WIN   = 3;
  localparam int QUAD  = 6;
  localparam int IDX_W = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             pixel_ready = 1'b0;
  logic             new_quadrant_row;
  logic             en, clear, new_row, new_vector;
  logic [1:0]       quadrant;
  logic             quadrant_lsb;
  logic [IDX_W-1:0] row_index;
  logic             pixel_valid, busy, done, sync_err;

  logic [IDX_W-1:0] col;
  logic [IDX_W-1:0] col_base;
  logic             kill_nqr = 1'b0;

  int checks = 0;
  int errors = 0;

  window_scan_sequencer #(.WIN(WIN), .QUAD(QUAD), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pixel_ready(pixel_ready),
    .new_quadrant_row(new_quadrant_row), .en(en), .clear(clear), .new_row(new_row),
    .new_vector(new_vector), .quadrant(quadrant), .quadrant_lsb(quadrant_lsb),
    .row_index(row_index), .pixel_valid(pixel_valid), .busy(busy), .done(done),
    .sync_err(sync_err)
  );

  always #5 clock = ~clock;

  // Column counter the sequencer is meant to drive.
  assign col_base         = quadrant_lsb ? IDX_W'(QUAD) : '0;
  assign new_quadrant_row = !kill_nqr && (col == col_base + IDX_W'(QUAD - 1));

  always @(posedge clock) begin
    if (!reset_n)   col <= '0;
    else if (clear) col <= col_base;
    else if (en) begin
      if (new_vector)   col <= (col == col_base + IDX_W'(QUAD - 1)) ? col_base : col + 1'b1;
      else if (new_row) col <= col - IDX_W'(WIN - 1);
      else              col <= col + 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; start = 1'b0; pixel_ready = 1'b0; kill_nqr = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({en, clear, new_row, new_vector, quadrant, quadrant_lsb, row_index,
                pixel_valid, busy, done, sync_err});
  endfunction

  // Reference: the full scan as an ordered list of pixels derived from the map geometry.
  typedef struct {int row; int col; bit nr; bit nv; bit wc_last;} pix_t;
  pix_t exp_q[$];

  task automatic build_model();
    exp_q.delete();
    for (int q = 0; q < 4; q++)
      for (int wr = 0; wr < QUAD / WIN; wr++)
        for (int wc = 0; wc < QUAD / WIN; wc++)
          for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
              exp_q.push_back('{row: (q / 2) * QUAD + wr * WIN + r,
                                col: (q % 2) * QUAD + wc * WIN + c,
                                nr: (c == WIN - 1) && (r < WIN - 1),
                                nv: (c == WIN - 1) && (r == WIN - 1),
                                wc_last: (wc == QUAD / WIN - 1)});
  endtask

  task automatic run_scan(input string tag, input int ready_pct, input bit poke, input bit kill);
    pix_t p;
    int   done_k = 0, done_cnt = 0, bad = 0;
    int   clr_k[$];
    bit   exp_sync = 1'b0;
    build_model();
    kill_nqr = kill;
    start = 1'b1; pixel_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      pixel_ready = (int'($urandom_range(99)) < ready_pct);
      start = poke ? 1'($urandom_range(1)) : 1'b0;
      #1;
      if (clear) clr_k.push_back(k);
      if (en !== (pixel_valid & pixel_ready)) bad++;
      if (!pixel_ready && (new_row || new_vector)) bad++;
      if (sync_err !== exp_sync) bad++;
      if (busy !== 1'b1) bad++;
      if (pixel_valid && pixel_ready) begin
        if (exp_q.size() == 0) bad++;
        else begin
          p = exp_q.pop_front();
          check({tag, " pixel"}, 32'({row_index, col, new_row, new_vector}),
                32'({4'(p.row), 4'(p.col), p.nr, p.nv}));
          if (p.nv && p.wc_last && kill) exp_sync = 1'b1;
        end
      end
      if (done) begin done_cnt++; done_k = k; end
      @(posedge clock); #1;
      if (done_k != 0) break;
    end
    start = 1'b0; kill_nqr = 1'b0;
    check({tag, " pixels_left"}, 32'(exp_q.size()), 0);
    check({tag, " done_pulses"}, 32'(done_cnt), 1);
    check({tag, " invariants"}, 32'(bad), 0);
    check({tag, " idle_after"}, 32'({busy, done, pixel_valid}), 0);
    check({tag, " sync_err"}, 32'(sync_err), 32'(exp_sync));
    if (ready_pct == 100) begin
      check({tag, " done_k"}, 32'(done_k), 149);
      for (int i = 0; i < 4; i++)
        check({tag, " clr_k"}, (i < clr_k.size()) ? 32'(clr_k[i]) : 32'hffff_ffff,
              32'(1 + 37 * i));
    end
  endtask

  typedef struct {
    logic start, ready;
    logic clr, valid, en, nr, nv;
    logic [3:0] row, col;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic rd, input logic cl, input logic v,
                              input logic e, input logic nr, input logic nv,
                              input int row, input int c);
    vec_t t;
    t.start = s; t.ready = rd; t.clr = cl; t.valid = v; t.en = e; t.nr = nr; t.nv = nv;
    t.row = 4'(row); t.col = 4'(c);
    return t;
  endfunction

  initial begin
    vec_t tbl[15];
    bit   found;

    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 1, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 1, 1, 0, 0, 0, 1);
    tbl[4]  = mk(0, 1, 0, 1, 1, 1, 0, 0, 2);
    tbl[5]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 0);
    tbl[6]  = mk(0, 1, 0, 1, 1, 0, 0, 1, 0);
    tbl[7]  = mk(1, 1, 0, 1, 1, 0, 0, 1, 1);
    tbl[8]  = mk(0, 1, 0, 1, 1, 1, 0, 1, 2);
    tbl[9]  = mk(0, 1, 0, 1, 1, 0, 0, 2, 0);
    tbl[10] = mk(0, 1, 0, 1, 1, 0, 0, 2, 1);
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 0, 2, 2);
    tbl[12] = mk(0, 1, 0, 1, 1, 0, 1, 2, 2);
    tbl[13] = mk(0, 1, 0, 1, 1, 0, 0, 0, 3);
    tbl[14] = mk(0, 1, 0, 1, 1, 0, 0, 0, 4);

    // Reset state.
    reset_n = 1'b0; pixel_ready = 1'b1; start = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", all_outputs(), 0);
    reset_n = 1'b1; start = 1'b0; pixel_ready = 1'b0;

    // Cycle table: start, first window, a mid-window stall and a last-pixel stall.
    foreach (tbl[i]) begin
      start = tbl[i].start; pixel_ready = tbl[i].ready;
      #1;
      check($sformatf("table[%0d]", i),
            32'({clear, pixel_valid, en, new_row, new_vector, row_index,
                 pixel_valid ? col : 4'd0}),
            32'({tbl[i].clr, tbl[i].valid, tbl[i].en, tbl[i].nr, tbl[i].nv, tbl[i].row,
                 tbl[i].valid ? tbl[i].col : 4'd0}));
      @(posedge clock); #1;
    end
    apply_reset();

    // Reset in the middle of quadrant 2.
    start = 1'b1; pixel_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (pixel_valid && quadrant == 2'd2 && row_index == 4'd7) begin found = 1'b1; break; end
      @(posedge clock); #1;
    end
    check("reach_q2_row7", 32'(found), 1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("midscan_reset_outputs", all_outputs(), 0);
    reset_n = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("restart_after_reset", 32'({clear, busy, quadrant, row_index}), 32'({2'b11, 2'd0, 4'd0}));
    apply_reset();

    // Five-cycle stall on the last pixel of window 1 (column 5).
    start = 1'b1; pixel_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pixel_valid && row_index == 4'd2 && col == 4'd5) begin found = 1'b1; break; end
      @(posedge clock); #1;
    end
    check("reach_col5", 32'(found), 1);
    pixel_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_hold", 32'({en, new_vector, pixel_valid, col}), 32'({3'b001, 4'd5}));
      @(posedge clock); #1;
    end
    pixel_ready = 1'b1;
    #1;
    check("stall_release", 32'({en, new_vector}), 32'(2'b11));
    @(posedge clock); #1;
    check("after_release", 32'({col, row_index, new_vector}), 32'({4'd0, 4'd3, 1'b0}));
    apply_reset();

    // Full scans: steady ready, start noise, random backpressure, corrupted feedback.
    run_scan("full", 100, 1'b0, 1'b0);
    run_scan("start_poke", 100, 1'b1, 1'b0);
    run_scan("rand60", 60, 1'b0, 1'b0);
    run_scan("rand30", 30, 1'b1, 1'b0);
    run_scan("kill_nqr", 100, 1'b0, 1'b1);
    run_scan("kill_nqr_rand", 50, 1'b0, 1'b1);

    // An accepted start clears the sticky error.
    start = 1'b1; pixel_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("start_clears_sync", 32'({sync_err, clear}), 32'(2'b01));
    apply_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_scan_sequencer.md
Name: window_scan_sequencer

Overview:
Drives the column index counter and supplies the matching row index, so the conv/pool stage walks a 12x12 feature map. The map is scanned as four 6x6 quadrants in order 00, 01, 10, 11. Each quadrant holds four non-overlapping 3x3 windows, read in raster order, and each window's pixels are also read in raster order. The block generates the counter's en/clear/new_row/new_vector/quadrant_lsb strobes and a pixel_valid/pixel_ready stream. It uses the counter's new_quadrant_row feedback as a consistency check.

Parameters:
WIN, 3, window edge in pixels (stride equals WIN, so windows do not overlap)
QUAD, 6, quadrant edge in pixels; QUAD = 2*WIN
IDX_W, 4, width of row_index; must match the column counter width

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
start  input  1  starts a full 144-pixel scan when the block is idle
pixel_ready  input  1  downstream accepts the current pixel
new_quadrant_row  input  1  feedback from the column counter
en  output  1  counter increment; equals pixel_valid AND pixel_ready
clear  output  1  counter load to base column
new_row  output  1  move to the next row within a window (counter steps back by WIN-1)
new_vector  output  1  end of a window
quadrant  output  2  current quadrant {row_half, col_half}
quadrant_lsb  output  1  quadrant[0]
row_index  output  IDX_W  map row of the current pixel
pixel_valid  output  1  a pixel address (row_index plus counter column) is presented
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the scan completes
sync_err  output  1  sticky; counter feedback disagrees with the sequencer

Behaviour:
- Reset (reset_n=0 at a clock edge): state goes to IDLE. All outputs are 0, including quadrant, row_index and sync_err. Reset wins over every other input, including mid-scan.
- States: IDLE -> CLR -> SCAN -> (CLR | FIN) -> IDLE.
- IDLE:
  - start=1 moves to CLR with quadrant=0.
  - sync_err is cleared when start is accepted.
  - start is ignored in every other state.
- CLR (exactly 1 cycle):
  - clear=1 with quadrant_lsb already at the new quadrant value, so the counter loads 0 or 6.
  - row_index = quadrant[1] ? 6 : 0.
  - Window counters wr, wc, r, c are reset to 0.
  - Next state is SCAN.
- SCAN:
  - pixel_valid=1. row_index = base_row + WIN*wr + r.
  - All strobes are gated by pixel_ready. While pixel_ready=0, en, new_row and new_vector are 0 and all state holds. A stall therefore has no effect at any point, including the last pixel of a window.
  - On an accepted pixel with c<WIN-1: c increments.
  - On an accepted pixel with c=WIN-1 and r<WIN-1: new_row=1, c=0, r increments.
  - On an accepted pixel with c=WIN-1 and r=WIN-1: new_vector=1, r=c=0, then the next window is selected:
    - if wc=0: wc becomes 1;
    - otherwise wc becomes 0 and wr increments;
    - if wr=1 and wc=1: the quadrant is finished; go to CLR with quadrant+1, or to FIN if quadrant=3.
- Counter check on each new_vector cycle:
  - new_quadrant_row is expected to equal (wc==1).
  - Any mismatch sets sync_err, which stays set until reset or an accepted start.
- FIN (1 cycle): done=1 and busy=1, then IDLE. quadrant returns to 0 on entry to IDLE.
- Latency with pixel_ready held at 1 and start accepted at edge E0, counting cycles k after E0:
  - CLR at k = 1, 38, 75, 112;
  - SCAN for the 36 cycles after each CLR;
  - done at k=149.
- Widths: row_index stays at or below 11. No arithmetic wraps within a legal scan.

Test Plan:
1. Reset mid-SCAN (quadrant 2, row_index 7) -> the next cycle shows all outputs 0 and state IDLE. start is then accepted normally.
2. start with pixel_ready=1 and a real column counter attached -> clear at k=1. Quadrant 0, window 0 presents pixels (r0,c0) (r0,c1) (r0,c2) (r1,c0) ... (r2,c2) in cycles k=2..10. new_row is seen at k=4 and k=7, new_vector at k=10. Window 1 covers columns 3-5 at rows 0-2. Window 2 sits at row_index 3-5, columns 0-2.
3. Full scan -> 144 pixel_valid&pixel_ready cycles. Quadrant 1 columns span 6-11 and quadrant 3 row_index spans 6-11. done pulses only at k=149. sync_err stays 0.
4. pixel_ready low for 5 cycles on the last pixel of a window (col 5) -> no en and no new_vector during the stall, and the counter holds 5. Release gives a single new_vector and the counter clears to base.
5. Force new_quadrant_row=0 while new_vector fires with wc=1 -> sync_err=1 and stays 1 to the end of the scan. The next start clears it.
6. start pulsed repeatedly during SCAN -> no restart; the k=149 timing is unchanged.
